// File: rtl/mem_dcache_if_if.sv
// Data-bus bundle between the MEM-stage access unit (master) and the data memory (slave).
// Signal suffixes are named from the master's point of view.
interface mem_dcache_if_if;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [63:0] bus_addr_o;
  logic [63:0] bus_wdata_o;
  logic [7:0]  bus_wstrb_o;
  logic [63:0] bus_rdata_i;
  logic        bus_ack_i;

  // req is held with addr/we/wdata/wstrb stable until a one-cycle ack pulse
  // (rdata valid alongside it) or until the master abandons on timeout.
  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o,
    input  bus_rdata_i, bus_ack_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o,
    output bus_rdata_i, bus_ack_i
  );
endinterface

// File: rtl/mem_dcache_if.sv
// MEM-stage data access unit: launches the EX/MEM load/store on a req/ack bus,
// lane-aligns stores, right-justifies loads, flags misalignment and bus timeouts.
module mem_dcache_if #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_mem_valid_i,
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic [63:0]     addr_i,
  input  logic [63:0]     store_data_i,
  mem_dcache_if_if.master bus,
  output logic            dcache_data_valid_o,
  output logic [63:0]     dcache_data_o,
  output logic            misalign_o,
  output logic            bus_err_o,
  output logic [1:0]      dbg_state_o
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam int         CW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_req;
  logic          r_we;
  logic [63:0]   r_addr;
  logic [63:0]   r_wdata;
  logic [7:0]    r_wstrb;
  logic [2:0]    r_off;
  logic [63:0]   r_data;
  logic          r_misalign;
  logic          r_err;
  logic [CW-1:0] r_cnt;

  logic          w_is_load;
  logic          w_is_store;
  logic          w_memop;
  logic          w_aligned;
  logic [2:0]    w_off;
  logic [7:0]    w_strb_base;
  logic [7:0]    w_strb;
  logic [63:0]   w_wdata;
  logic [63:0]   w_load_data;

  assign w_is_load  = (opcode_i == OP_LOAD);
  assign w_is_store = (opcode_i == OP_STORE);
  assign w_memop    = ex_mem_valid_i & (w_is_load | w_is_store);
  assign w_off      = addr_i[2:0];

  // Size decode: natural alignment and the unshifted byte-enable pattern.
  always_comb begin
    w_aligned   = 1'b1;
    w_strb_base = 8'h01;
    case (funct3_i[1:0])
      2'd0: begin w_aligned = 1'b1;              w_strb_base = 8'h01; end
      2'd1: begin w_aligned = (w_off[0] == 1'b0);  w_strb_base = 8'h03; end
      2'd2: begin w_aligned = (w_off[1:0] == 2'b0); w_strb_base = 8'h0F; end
      default: begin w_aligned = (w_off == 3'b0);  w_strb_base = 8'hFF; end
    endcase
  end

  assign w_strb      = w_strb_base << w_off;
  assign w_wdata     = store_data_i << {w_off, 3'b000};
  assign w_load_data = bus.bus_rdata_i >> {r_off, 3'b000};

  // MEM may advance when no memory op is pending or a result is being presented.
  assign dcache_data_valid_o = ((r_state == S_IDLE) & ~w_memop) | (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_off      <= '0;
      r_data     <= '0;
      r_misalign <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_memop) begin
            if (w_aligned) begin
              r_req   <= 1'b1;
              r_we    <= w_is_store;
              r_addr  <= {addr_i[63:3], 3'b000};
              r_wdata <= w_wdata;
              r_wstrb <= w_strb;
              r_off   <= w_off;
              r_cnt   <= '0;
              r_state <= S_WAIT;
            end else begin
              r_misalign <= 1'b1;
              r_data     <= '0;
              r_state    <= S_DONE;
            end
          end
        end
        S_WAIT: begin
          // An ack on the final allowed cycle still completes normally.
          if (bus.bus_ack_i) begin
            r_data  <= r_we ? 64'd0 : w_load_data;
            r_req   <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            r_data  <= '0;
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_misalign <= 1'b0;
          r_err      <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.bus_req_o   = r_req;
  assign bus.bus_we_o    = r_we;
  assign bus.bus_addr_o  = r_addr;
  assign bus.bus_wdata_o = r_wdata;
  assign bus.bus_wstrb_o = r_wstrb;

  assign dcache_data_o = r_data;
  assign misalign_o    = r_misalign;
  assign bus_err_o     = r_err;
  assign dbg_state_o   = r_state;
endmodule

// File: tb/tb_mem_dcache_if.sv
// Directed plus random bench for mem_dcache_if against a byte-level reference model.
module tb_mem_dcache_if;
  localparam int TO = 4;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_ALU = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_mem_valid = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [63:0] addr = '0;
  logic [63:0] store_data = '0;
  logic        dv;
  logic [63:0] dcache_data;
  logic        misalign;
  logic        bus_err;
  logic [1:0]  dbg_state;
  logic [63:0] exp_data = '0;
  int          n_assert = 0;
  int          n_fail = 0;

  mem_dcache_if_if bus ();

  mem_dcache_if #(.TIMEOUT_CYC(TO)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ex_mem_valid_i      (ex_mem_valid),
    .opcode_i            (opcode),
    .funct3_i            (funct3),
    .addr_i              (addr),
    .store_data_i        (store_data),
    .bus                 (bus),
    .dcache_data_valid_o (dv),
    .dcache_data_o       (dcache_data),
    .misalign_o          (misalign),
    .bus_err_o           (bus_err),
    .dbg_state_o         (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle with no memory op in EX/MEM; stray acks must not disturb anything.
  task automatic idle_cycle(input logic alu_valid, input logic ack_noise);
    ex_mem_valid = alu_valid;
    opcode = ($urandom_range(0, 1) == 0) ? OP_ALU : 7'b0010011;
    bus.bus_ack_i = ack_noise;
    bus.bus_rdata_i = {$urandom, $urandom};
    @(negedge clk);
    chk("idle_valid", dv, 1);
    chk("idle_req", bus.bus_req_o, 0);
    chk("idle_misalign", misalign, 0);
    chk("idle_err", bus_err, 0);
    chk("idle_data_hold", dcache_data, exp_data);
    @(posedge clk); #1;
    bus.bus_ack_i = 1'b0;
    ex_mem_valid = 1'b0;
  endtask

  // Issue one load/store; ack_dly < 0 means the bus never answers.
  task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] sd, input int ack_dly, input logic [63:0] rd);
    int nb, off, req_cycles, exp_req_cycles;
    logic is_ld, aligned, timeout, done;
    logic [7:0]  e_strb;
    logic [63:0] e_wdata, e_load, e_res;
    nb = 1 << f3[1:0];
    off = int'(a[2:0]);
    is_ld = (op == OP_LD);
    aligned = (off % nb) == 0;
    e_strb = '0;
    e_wdata = '0;
    e_load = '0;
    for (int b = 0; b < 8; b++) begin
      if (b >= off && b < off + nb) e_strb[b] = 1'b1;
      if (b + off < 8) begin
        e_wdata[(b + off) * 8 +: 8] = sd[b * 8 +: 8];
        e_load[b * 8 +: 8] = rd[(b + off) * 8 +: 8];
      end
    end
    timeout = (ack_dly < 0) || (ack_dly >= TO);
    exp_req_cycles = timeout ? TO : ack_dly + 1;

    ex_mem_valid = 1'b1;
    opcode = op;
    funct3 = f3;
    addr = a;
    store_data = sd;
    @(negedge clk);
    chk("stall_valid", dv, 0);
    chk("stall_misalign", misalign, 0);
    chk("stall_err", bus_err, 0);
    @(posedge clk); #1;
    if (!aligned) begin
      @(negedge clk);
      chk("mis_valid", dv, 1);
      chk("mis_pulse", misalign, 1);
      chk("mis_req", bus.bus_req_o, 0);
      chk("mis_err", bus_err, 0);
      chk("mis_data", dcache_data, 0);
      exp_data = '0;
    end else begin
      req_cycles = 0;
      done = 1'b0;
      for (int c = 0; c < 16 && !done; c++) begin
        @(negedge clk);
        if (dv) begin
          done = 1'b1;
        end else begin
          req_cycles++;
          chk("wait_req", bus.bus_req_o, 1);
          chk("wait_we", bus.bus_we_o, !is_ld);
          chk("wait_addr", bus.bus_addr_o, {a[63:3], 3'b000});
          chk("wait_wstrb", bus.bus_wstrb_o, e_strb);
          if (!is_ld) chk("wait_wdata", bus.bus_wdata_o, e_wdata);
          bus.bus_ack_i = (c == ack_dly);
          bus.bus_rdata_i = rd;
          @(posedge clk); #1;
          bus.bus_ack_i = 1'b0;
          bus.bus_rdata_i = {$urandom, $urandom};
        end
      end
      chk("done_reached", done, 1);
      chk("req_cycles", req_cycles, exp_req_cycles);
      chk("done_req", bus.bus_req_o, 0);
      chk("done_err", bus_err, timeout);
      chk("done_misalign", misalign, 0);
      e_res = (timeout || !is_ld) ? 64'd0 : e_load;
      chk("done_data", dcache_data, e_res);
      exp_data = e_res;
    end
    @(posedge clk); #1;
    ex_mem_valid = 1'b0;
  endtask

  initial begin
    bus.bus_ack_i = 1'b0;
    bus.bus_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req", bus.bus_req_o, 0);
    chk("rst_we", bus.bus_we_o, 0);
    chk("rst_addr", bus.bus_addr_o, 0);
    chk("rst_wdata", bus.bus_wdata_o, 0);
    chk("rst_wstrb", bus.bus_wstrb_o, 0);
    chk("rst_data", dcache_data, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_valid", dv, 1);
    @(posedge clk); #1;

    // ld, zero-wait ack: minimum latency
    run_op(OP_LD, 3'd3, 64'h1000, 64'h0, 0, 64'h1122334455667788);
    chk("t1_data", dcache_data, 64'h1122334455667788);
    // lb at byte 5, back to back
    run_op(OP_LD, 3'd0, 64'h1005, 64'h0, 0, 64'h1122334455667788);
    chk("t2_byte", dcache_data[7:0], 8'h33);
    // sh to upper half-word, ack delayed two cycles
    run_op(OP_ST, 3'd1, 64'h2006, 64'hABCD, 2, 64'h0);
    idle_cycle(1'b1, 1'b1);
    // misaligned lw
    run_op(OP_LD, 3'd2, 64'h1002, 64'h0, 0, 64'h0);
    idle_cycle(1'b0, 1'b0);
    // timeout, then ack on the last allowed cycle
    run_op(OP_LD, 3'd3, 64'h3000, 64'h0, -1, 64'h0);
    run_op(OP_LD, 3'd3, 64'h3008, 64'h0, TO - 1, 64'hCAFEF00DDEADBEEF);
    chk("t5_late_ack", dcache_data, 64'hCAFEF00DDEADBEEF);

    // reset while waiting on the bus
    ex_mem_valid = 1'b1;
    opcode = OP_LD;
    funct3 = 3'd3;
    addr = 64'h4000;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstw_req_before", bus.bus_req_o, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ex_mem_valid = 1'b0;
    exp_data = '0;
    @(negedge clk);
    chk("rstw_req", bus.bus_req_o, 0);
    chk("rstw_valid", dv, 1);
    chk("rstw_err", bus_err, 0);
    chk("rstw_misalign", misalign, 0);
    @(posedge clk); #1;
    idle_cycle(1'b1, 1'b0);
    idle_cycle(1'b0, 1'b1);

    // random mix
    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 9) begin
        idle_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        run_op((sel < 5) ? OP_LD : OP_ST, 3'($urandom_range(0, 7)),
               {$urandom, $urandom}, {$urandom, $urandom},
               int'($urandom_range(0, 6)) - 1, {$urandom, $urandom});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
